// File: rtl/song_player_if.sv
// ---------------------------------------------------------------------------
// song_player_if
//
// Purpose: groups the control, score-write and playback-status signals of
// song_player into one bundle. Clock and reset stay plain module ports.
//
// Signals:
//   start    controller -> player  one-cycle pulse, begin playback at entry 0
//   stop     controller -> player  one-cycle pulse, abort playback
//   wr_en    controller -> player  score write strobe
//   wr_addr  controller -> player  score write address (0..31)
//   wr_data  controller -> player  score entry {end, rest, note[3:0], dur-1[2:0]}
//   note     player -> controller  one-hot note select, 0 = silence
//   playing  player -> controller  high whenever the player is not idle
//   pos      player -> controller  address of the current score entry
//   done     player -> controller  one-cycle pulse at the end of the score
//
// Modports:
//   master  the side that drives commands and score writes
//   slave   the player itself
// ---------------------------------------------------------------------------
interface song_player_if;
    logic        start;
    logic        stop;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [8:0]  wr_data;
    logic [15:0] note;
    logic        playing;
    logic [4:0]  pos;
    logic        done;

    modport master (
        output start, stop, wr_en, wr_addr, wr_data,
        input  note, playing, pos, done
    );

    modport slave (
        input  start, stop, wr_en, wr_addr, wr_data,
        output note, playing, pos, done
    );
endinterface

// File: rtl/song_player.sv
// ---------------------------------------------------------------------------
// song_player
//
// Purpose: plays a score of up to 32 entries held in an internal register
// array. Each entry selects one of 16 notes (or a rest) for 1..8 beats; the
// last GAP_CYCLES of every entry are silent so repeated notes are audible as
// separate notes. Playback stops at an entry with the end marker set, or
// after entry 31.
//
// Parameters:
//   BEAT_CYCLES  clk cycles per beat
//   GAP_CYCLES   silent cycles at the end of each entry, 1..BEAT_CYCLES-1
//
// Ports:
//   clk  input  rising-edge clock for all state
//   rst  input  asynchronous, active-high reset
//   bus  song_player_if.slave  start/stop pulses, score writes, note output
//        and playback status (see song_player_if.sv)
//
// Configuration macro:
//   SONG_PLAYER_LOOP_EN  when defined, the end of the score restarts
//                        playback at entry 0 (done still pulses every
//                        pass); when undefined, playback returns to idle.
//
// Entry timing: 1 FETCH cycle + (dur+1)*BEAT_CYCLES - GAP_CYCLES PLAY
// cycles + GAP_CYCLES GAP cycles = 1 + (dur+1)*BEAT_CYCLES cycles.
// ---------------------------------------------------------------------------
module song_player #(
    parameter int unsigned BEAT_CYCLES = 12500000,
    parameter int unsigned GAP_CYCLES  = 500000
) (
    input logic          clk,
    input logic          rst,
    song_player_if.slave bus
);

    // -----------------------------------------------------------------------
    // Types and constants
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        PLAY  = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Field layout of one score word.
    typedef struct packed {
        logic       end_mark;
        logic       rest;
        logic [3:0] idx;
        logic [2:0] dur;
    } entry_t;

    localparam logic [31:0] BEAT_LEN  = 32'(BEAT_CYCLES);
    localparam logic [31:0] GAP_LEN   = 32'(GAP_CYCLES);
    localparam logic [4:0]  LAST_ADDR = 5'd31;
    localparam logic [8:0]  EMPTY_ENTRY = 9'h100;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [4:0]  pos_q,   pos_d;
    logic [31:0] cnt_q,   cnt_d;     // cycles left in the current PLAY or GAP
    logic [3:0]  idx_q,   idx_d;     // note index latched at FETCH
    logic        rest_q,  rest_d;    // rest flag latched at FETCH
    logic [15:0] note_q,  note_d;

    logic [8:0]  score_q [32];
    entry_t      cur_entry;

    assign cur_entry = entry_t'(score_q[pos_q]);

    // -----------------------------------------------------------------------
    // Score storage
    // -----------------------------------------------------------------------
    // Writes are accepted in every state. The entry being played is not
    // disturbed because its fields were copied into idx_q/rest_q/cnt_q at
    // FETCH; new content is seen only on the next fetch of that address.
    // NOTE: the array is deliberately reset (every word becomes an end
    // marker) so a start with an unwritten score ends immediately instead of
    // playing garbage; this forces flops rather than a RAM macro, which is
    // acceptable at 32x9.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                score_q[i] <= EMPTY_ENTRY;
            end
        end else if (bus.wr_en) begin
            score_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 1: state and datapath registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values computed before this edge regardless of
    // statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            rest_q  <= 1'b0;
            note_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rest_q  <= rest_d;
            note_q  <= note_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next state and datapath next values
    // -----------------------------------------------------------------------
    // NOTE: every variable gets a hold-value default before the case so no
    // path through this block leaves one unassigned (which would infer a
    // latch).
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rest_d  = rest_q;

        unique case (state_q)
            IDLE: begin
                // stop wins over a simultaneous start.
                if (bus.start && !bus.stop) begin
                    state_d = FETCH;
                    pos_d   = '0;
                end
            end

            FETCH: begin
                if (cur_entry.end_mark) begin
                    state_d = DONE;
                end else begin
                    idx_d   = cur_entry.idx;
                    rest_d  = cur_entry.rest;
                    // At most 8*BEAT_CYCLES, so 32 bits never wrap for any
                    // legal BEAT_CYCLES; GAP_CYCLES < BEAT_CYCLES keeps this
                    // count at least 1.
                    cnt_d   = ({29'd0, cur_entry.dur} + 32'd1) * BEAT_LEN - GAP_LEN;
                    state_d = PLAY;
                end
            end

            PLAY: begin
                // The count was loaded with the number of PLAY cycles, so
                // the cycle that sees 1 is the last one.
                if (cnt_q == 32'd1) begin
                    cnt_d   = GAP_LEN;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end

            GAP: begin
                if (cnt_q == 32'd1) begin
                    if (pos_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        pos_d   = pos_q + 5'd1;
                        state_d = FETCH;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end

            DONE: begin
`ifdef SONG_PLAYER_LOOP_EN
                state_d = FETCH;
                pos_d   = '0;
`else
                state_d = IDLE;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides every transition above; pos keeps its value so
        // the controller can see where playback stopped.
        if (bus.stop && (state_q != IDLE)) begin
            state_d = IDLE;
            pos_d   = pos_q;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 3: outputs
    // -----------------------------------------------------------------------
    // note is computed from the *next* state so that the registered note_q
    // is aligned cycle-for-cycle with state_q == PLAY: it turns on with the
    // first PLAY cycle and off with the first GAP cycle. Being a flop with
    // async reset, it also drops to zero the moment rst rises.
    always_comb begin
        note_d = '0;
        if ((state_d == PLAY) && !rest_d) begin
            note_d = 16'd1 << idx_d;
        end
    end

    assign bus.note    = note_q;
    assign bus.pos     = pos_q;
    assign bus.playing = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);

endmodule
